vga_layer_mixer: RTL and testbench

Parametrised pixel compositor between the game logic and the board's VGA colour outputs. Merges `n_layers` prioritised game RGB layers over a background containing a filled square, blanks outside the active area and expands 1-bit-per-channel colour to the board's channel widths. Pipelined (2-cycle latency) and, when configured, moves the square once per frame with edge bounce.

---
 rtl/vga_mixer_pkg.sv | 22 ++
 rtl/vga_square_mover.sv | 107 ++++++++++
 rtl/vga_layer_mixer.sv | 128 ++++++++++++
 tb/tb_vga_layer_mixer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vga_mixer_pkg.sv
// Shared colour types, constants and channel-expansion helper for the VGA mixer.
package vga_mixer_pkg;

  typedef logic [2:0] rgb_t;

  localparam rgb_t RGB_BLACK = 3'b000;
  localparam rgb_t RGB_WHITE = 3'b111;

  // Widest output channel the expansion helper can produce.
  localparam int unsigned CH_W_MAX = 16;

  // Replicate one colour bit across the low 'width' bits of a channel.
  function automatic logic [CH_W_MAX-1:0] rgb_expand(input logic bit_in, input int unsigned width);
    logic [CH_W_MAX-1:0] ch;
    ch = '0;
    for (int unsigned i = 0; i < CH_W_MAX; i++) begin
      if (i < width) ch[i] = bit_in;
    end
    return ch;
  endfunction

endpackage

// File: rtl/vga_square_mover.sv
// Square position / direction state and frame tick.
// Motion is enabled by defining VGA_LAYER_MIXER_BOUNCE_EN; otherwise the square
// stays centred and freeze is ignored.
module vga_square_mover #(
  parameter int unsigned screen_width  = 640,
  parameter int unsigned screen_height = 480,
  parameter int unsigned w_x           = $clog2(screen_width),
  parameter int unsigned w_y           = $clog2(screen_height),
  parameter int unsigned sq_size       = 100,
  parameter int unsigned sq_step       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_end,
  input  logic         freeze,
  output logic [w_x:0] sq_x,
  output logic [w_y:0] sq_y,
  output logic         frame_tick
);

  localparam int unsigned XW = w_x + 1;
  localparam int unsigned YW = w_y + 1;

  localparam logic [XW-1:0] X_INIT = XW'((screen_width - sq_size) / 2);
  localparam logic [YW-1:0] Y_INIT = YW'((screen_height - sq_size) / 2);

  // Tick pulses in the cycle after the last active pixel leaves stage 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_tick <= 1'b0;
    else      frame_tick <= frame_end;
  end

`ifdef VGA_LAYER_MIXER_BOUNCE_EN
  localparam logic [XW-1:0] X_MAX  = XW'(screen_width - sq_size);
  localparam logic [YW-1:0] Y_MAX  = YW'(screen_height - sq_size);
  localparam logic [XW-1:0] X_DIM  = XW'(screen_width);
  localparam logic [YW-1:0] Y_DIM  = YW'(screen_height);
  localparam logic [XW-1:0] X_SIZE = XW'(sq_size);
  localparam logic [YW-1:0] Y_SIZE = YW'(sq_size);
  localparam logic [XW-1:0] X_STEP = XW'(sq_step);
  localparam logic [YW-1:0] Y_STEP = YW'(sq_step);

  logic [XW-1:0] pos_x, pos_x_nxt;
  logic [YW-1:0] pos_y, pos_y_nxt;
  logic          dir_x, dir_x_nxt;
  logic          dir_y, dir_y_nxt;

  // Bounce arithmetic: clamp to the screen edge and reverse on overshoot.
  always_comb begin
    pos_x_nxt = pos_x;
    dir_x_nxt = dir_x;
    pos_y_nxt = pos_y;
    dir_y_nxt = dir_y;
    if (dir_x) begin
      if (pos_x + X_STEP + X_SIZE > X_DIM) begin
        pos_x_nxt = X_MAX;
        dir_x_nxt = 1'b0;
      end else begin
        pos_x_nxt = pos_x + X_STEP;
      end
    end else if (pos_x < X_STEP) begin
      pos_x_nxt = '0;
      dir_x_nxt = 1'b1;
    end else begin
      pos_x_nxt = pos_x - X_STEP;
    end
    if (dir_y) begin
      if (pos_y + Y_STEP + Y_SIZE > Y_DIM) begin
        pos_y_nxt = Y_MAX;
        dir_y_nxt = 1'b0;
      end else begin
        pos_y_nxt = pos_y + Y_STEP;
      end
    end else if (pos_y < Y_STEP) begin
      pos_y_nxt = '0;
      dir_y_nxt = 1'b1;
    end else begin
      pos_y_nxt = pos_y - Y_STEP;
    end
  end

  // Position moves on the same edge that raises frame_tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x <= X_INIT;
      pos_y <= Y_INIT;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (frame_end && !freeze) begin
      pos_x <= pos_x_nxt;
      pos_y <= pos_y_nxt;
      dir_x <= dir_x_nxt;
      dir_y <= dir_y_nxt;
    end
  end

  assign sq_x = pos_x;
  assign sq_y = pos_y;
`else
  logic unused_freeze;
  assign unused_freeze = freeze;

  assign sq_x = X_INIT;
  assign sq_y = Y_INIT;
`endif

endmodule

// File: rtl/vga_layer_mixer.sv
// Two-stage layer compositor: prioritised game layers over a background with a
// (optionally bouncing) square, blanking and channel expansion.
// Optional feature macro: VGA_LAYER_MIXER_BOUNCE_EN.
module vga_layer_mixer
  import vga_mixer_pkg::*;
#(
  parameter int unsigned screen_width  = 640,
  parameter int unsigned screen_height = 480,
  parameter int unsigned w_x           = $clog2(screen_width),
  parameter int unsigned w_y           = $clog2(screen_height),
  parameter int unsigned n_layers      = 2,
  parameter int unsigned w_red         = 4,
  parameter int unsigned w_green       = 4,
  parameter int unsigned w_blue        = 4,
  parameter int unsigned sq_size       = 100,
  parameter int unsigned sq_step       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  display_on,
  input  logic [w_x-1:0]        x,
  input  logic [w_y-1:0]        y,
  input  logic [3*n_layers-1:0] layer_rgb,
  input  logic [n_layers-1:0]   layer_en,
  input  logic [2:0]            bg_rgb,
  input  logic [2:0]            sq_rgb,
  input  logic                  sq_en,
  input  logic                  freeze,
  output logic [w_red-1:0]      red,
  output logic [w_green-1:0]    green,
  output logic [w_blue-1:0]     blue,
  output logic                  frame_tick
);

  localparam int unsigned XW = w_x + 1;
  localparam int unsigned YW = w_y + 1;

  logic [XW-1:0] sq_x;
  logic [YW-1:0] sq_y;

  logic                  s1_display_on;
  logic [w_x-1:0]        s1_x;
  logic [w_y-1:0]        s1_y;
  logic [3*n_layers-1:0] s1_layer_rgb;
  logic [n_layers-1:0]   s1_layer_en;
  rgb_t                  s1_bg_rgb;
  rgb_t                  s1_sq_rgb;
  logic                  s1_hit;

  logic hit_c;
  logic frame_end_c;
  rgb_t pixel_c;

  vga_square_mover #(
    .screen_width (screen_width),
    .screen_height(screen_height),
    .w_x          (w_x),
    .w_y          (w_y),
    .sq_size      (sq_size),
    .sq_step      (sq_step)
  ) u_mover (
    .clk       (clk),
    .rst       (rst),
    .frame_end (frame_end_c),
    .freeze    (freeze),
    .sq_x      (sq_x),
    .sq_y      (sq_y),
    .frame_tick(frame_tick)
  );

  // Square hit test against the current position, widened to avoid wrap.
  always_comb begin
    hit_c = sq_en
         && (XW'(x) >= sq_x) && (XW'(x) < sq_x + XW'(sq_size))
         && (YW'(y) >= sq_y) && (YW'(y) < sq_y + YW'(sq_size));
  end

  // Stage 1: capture the pixel and its hit result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_display_on <= 1'b0;
      s1_x          <= '0;
      s1_y          <= '0;
      s1_layer_rgb  <= '0;
      s1_layer_en   <= '0;
      s1_bg_rgb     <= RGB_BLACK;
      s1_sq_rgb     <= RGB_BLACK;
      s1_hit        <= 1'b0;
    end else begin
      s1_display_on <= display_on;
      s1_x          <= x;
      s1_y          <= y;
      s1_layer_rgb  <= layer_rgb;
      s1_layer_en   <= layer_en;
      s1_bg_rgb     <= bg_rgb;
      s1_sq_rgb     <= sq_rgb;
      s1_hit        <= hit_c;
    end
  end

  // Last active pixel of the frame is sitting in stage 1.
  assign frame_end_c = s1_display_on
                    && (s1_x == w_x'(screen_width - 1))
                    && (s1_y == w_y'(screen_height - 1));

  // Priority select; descending scan so the lowest enabled opaque layer wins.
  always_comb begin
    pixel_c = s1_hit ? s1_sq_rgb : s1_bg_rgb;
    for (int i = n_layers - 1; i >= 0; i--) begin
      if (s1_layer_en[i] && (s1_layer_rgb[3*i +: 3] != RGB_BLACK)) pixel_c = s1_layer_rgb[3*i +: 3];
    end
    if (!s1_display_on) pixel_c = RGB_BLACK;
  end

  // Stage 2: registered, expanded colour outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= w_red'(rgb_expand(pixel_c[2], w_red));
      green <= w_green'(rgb_expand(pixel_c[1], w_green));
      blue  <= w_blue'(rgb_expand(pixel_c[0], w_blue));
    end
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer (default parameters, n_layers = 2).
module tb_vga_layer_mixer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       display_on = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic [5:0] layer_rgb = '0;
  logic [1:0] layer_en = '0;
  logic [2:0] bg_rgb = '0;
  logic [2:0] sq_rgb = '0;
  logic       sq_en = 1'b0;
  logic       freeze = 1'b0;
  logic [3:0] red, green, blue;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;

  always #5 clk = ~clk;

  vga_layer_mixer dut (
    .clk(clk), .rst(rst), .display_on(display_on), .x(x), .y(y),
    .layer_rgb(layer_rgb), .layer_en(layer_en), .bg_rgb(bg_rgb),
    .sq_rgb(sq_rgb), .sq_en(sq_en), .freeze(freeze),
    .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
  );

  typedef struct {
    logic        disp;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [5:0]  lrgb;
    logic [1:0]  len;
    logic [2:0]  bg;
    logic [2:0]  sq;
    logic        sqe;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic d, input logic [9:0] px, input logic [8:0] py,
                       input logic [5:0] lr, input logic [1:0] le, input logic [2:0] bg,
                       input logic [2:0] sq, input logic se);
    display_on = d; x = px; y = py; layer_rgb = lr; layer_en = le;
    bg_rgb = bg; sq_rgb = sq; sq_en = se;
  endtask

  // Present one pixel and return its colour two cycles later.
  task automatic probe(input logic d, input logic [9:0] px, input logic [8:0] py,
                       input logic [5:0] lr, input logic [1:0] le, input logic [2:0] bg,
                       input logic [2:0] sq, input logic se, output logic [11:0] got);
    drive(d, px, py, lr, le, bg, sq, se);
    @(posedge clk); #1;
    @(posedge clk); #1;
    got = {red, green, blue};
  endtask

  // Square corners present at (ex,ey) and (ex+99,ey+99), absent just outside.
  task automatic check_pos(input string name, input int ex, input int ey);
    logic [11:0] g;
    probe(1'b1, 10'(ex), 9'(ey), 6'b0, 2'b00, 3'b000, 3'b010, 1'b1, g);
    check({name, "_tl"}, g, 12'h0F0);
    probe(1'b1, 10'(ex - 1), 9'(ey), 6'b0, 2'b00, 3'b000, 3'b010, 1'b1, g);
    check({name, "_left"}, g, 12'h000);
    probe(1'b1, 10'(ex), 9'(ey - 1), 6'b0, 2'b00, 3'b000, 3'b010, 1'b1, g);
    check({name, "_above"}, g, 12'h000);
    probe(1'b1, 10'(ex + 99), 9'(ey + 99), 6'b0, 2'b00, 3'b000, 3'b010, 1'b1, g);
    check({name, "_br"}, g, 12'h0F0);
  endtask

  // Present the last active pixel n times, each followed by a non-final pixel.
  task automatic do_ticks(input int n, input logic frz);
    freeze = frz;
    drive(1'b1, 10'd0, 9'd0, 6'b0, 2'b00, 3'b000, 3'b000, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 10'd639, 9'd479, 6'b0, 2'b00, 3'b000, 3'b000, 1'b0);
      @(posedge clk); #1;
      if (frame_tick) begin
        errors++;
        $display("FAIL tick_early: frame_tick=1 expected 0 at tick %0d", i);
      end
      drive(1'b1, 10'd0, 9'd0, 6'b0, 2'b00, 3'b000, 3'b000, 1'b0);
      @(posedge clk); #1;
      if (frame_tick) ticks_seen++;
    end
    freeze = 1'b0;
  endtask

  initial begin
    logic [11:0] g;
    vecs[0]  = '{1'b1, 10'd0,   9'd0,   6'b000000, 2'b00, 3'b101, 3'b000, 1'b0, 12'hF0F};
    vecs[1]  = '{1'b1, 10'd270, 9'd190, 6'b000000, 2'b00, 3'b101, 3'b010, 1'b1, 12'h0F0};
    vecs[2]  = '{1'b1, 10'd370, 9'd190, 6'b000000, 2'b00, 3'b101, 3'b010, 1'b1, 12'hF0F};
    vecs[3]  = '{1'b1, 10'd369, 9'd289, 6'b000000, 2'b00, 3'b101, 3'b010, 1'b1, 12'h0F0};
    vecs[4]  = '{1'b1, 10'd270, 9'd290, 6'b000000, 2'b00, 3'b101, 3'b010, 1'b1, 12'hF0F};
    vecs[5]  = '{1'b1, 10'd0,   9'd0,   6'b100001, 2'b11, 3'b000, 3'b000, 1'b0, 12'h00F};
    vecs[6]  = '{1'b1, 10'd0,   9'd0,   6'b100001, 2'b10, 3'b000, 3'b000, 1'b0, 12'hF00};
    vecs[7]  = '{1'b1, 10'd0,   9'd0,   6'b100000, 2'b11, 3'b000, 3'b000, 1'b0, 12'hF00};
    vecs[8]  = '{1'b0, 10'd0,   9'd0,   6'b000111, 2'b01, 3'b101, 3'b000, 1'b0, 12'h000};
    vecs[9]  = '{1'b1, 10'd300, 9'd200, 6'b011000, 2'b10, 3'b000, 3'b010, 1'b1, 12'h0FF};
    vecs[10] = '{1'b1, 10'd270, 9'd190, 6'b000000, 2'b00, 3'b001, 3'b010, 1'b0, 12'h00F};
    vecs[11] = '{1'b1, 10'd700, 9'd200, 6'b000000, 2'b00, 3'b110, 3'b010, 1'b1, 12'hFF0};
    vecs[12] = '{1'b1, 10'd300, 9'd200, 6'b000111, 2'b01, 3'b000, 3'b010, 1'b1, 12'hFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", {red, green, blue}, 12'h000);
    check("reset_tick", {11'b0, frame_tick}, 12'h000);
    rst = 1'b1;

    // Table-driven single-pixel vectors
    for (int i = 0; i < 13; i++) begin
      probe(vecs[i].disp, vecs[i].px, vecs[i].py, vecs[i].lrgb, vecs[i].len,
            vecs[i].bg, vecs[i].sq, vecs[i].sqe, g);
      check($sformatf("vec%0d", i), g, vecs[i].exp_rgb);
    end

    // Back-to-back pixels: one per clock, each emerging two cycles later
    drive(1'b1, 10'd0, 9'd0, 6'b0, 2'b00, 3'b100, 3'b000, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 10'd0, 9'd0, 6'b0, 2'b00, 3'b010, 3'b000, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 10'd0, 9'd0, 6'b0, 2'b00, 3'b001, 3'b000, 1'b0);
    check("stream0", {red, green, blue}, 12'hF00);
    @(posedge clk); #1;
    check("stream1", {red, green, blue}, 12'h0F0);
    @(posedge clk); #1;
    check("stream2", {red, green, blue}, 12'h00F);

    // Asynchronous reset mid-frame
    probe(1'b1, 10'd5, 9'd5, 6'b000111, 2'b01, 3'b000, 3'b000, 1'b0, g);
    check("pre_rst", g, 12'hFFF);
    #2 rst = 1'b0;
    #1;
    check("async_rst", {red, green, blue}, 12'h000);
    @(posedge clk); #1;
    rst = 1'b1;

    check_pos("centre", 270, 190);

`ifdef VGA_LAYER_MIXER_BOUNCE_EN
    do_ticks(135, 1'b0);
    check_pos("tick135", 540, 302);
    do_ticks(1, 1'b0);
    check_pos("tick136", 540, 300);
    do_ticks(1, 1'b0);
    check_pos("tick137", 538, 298);
    do_ticks(5, 1'b1);
    check_pos("frozen", 538, 298);
    check("tick_count", 12'(ticks_seen), 12'd142);
`else
    do_ticks(100, 1'b0);
    do_ticks(100, 1'b1);
    check_pos("static", 270, 190);
    check("tick_count", 12'(ticks_seen), 12'd200);
`endif

    // Last pixel with display_on low is not a frame end
    drive(1'b0, 10'd639, 9'd479, 6'b0, 2'b00, 3'b000, 3'b000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("no_tick_blank", {11'b0, frame_tick}, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
